// File: rtl/dem_pkg.sv
// rtl/dem_pkg.sv - shared constants, FSM state type and width helpers for the DEM decoder
package dem_pkg;

  localparam int SWITCH_WIDTH = 8;
  localparam int STATE_W      = 2;
  localparam int ERR_CNT_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } dem_state_e;

  function automatic int cnt_width(input int window);
    return $clog2(window);
  endfunction

  // Wide enough to hold a full window of worst-case switching words
  function automatic int acc_width(input int window, input int sw);
    return $clog2(window) + sw;
  endfunction

endpackage

// File: rtl/dem_skid_fifo.sv
// rtl/dem_skid_fifo.sv - 2-entry registered FIFO; s_tready = not full, m_tvalid = not empty
module dem_skid_fifo #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign s_tready = (count != 2'd2);
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dem_decoder.sv
// rtl/dem_decoder.sv - DEM decoder: branch sum, window balance monitor, output FIFO.
// Optional DEM_DEC_CHECK_EN adds err_cnt_o, counting words where x1 - x2 != s.
module dem_decoder #(
  parameter int SWITCH_WIDTH = dem_pkg::SWITCH_WIDTH,
  parameter int WINDOW       = 64,
  parameter int BAL_LIMIT    = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [SWITCH_WIDTH-1:0] x_out1_i,
  input  logic [SWITCH_WIDTH-1:0] x_out2_i,
  input  logic [SWITCH_WIDTH-1:0] s_in_i,
  input  logic                    clear_i,
  output logic [SWITCH_WIDTH:0]   y_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    imbalance_o,
  output logic [1:0]              state_o
`ifdef DEM_DEC_CHECK_EN
  ,
  output logic [15:0]             err_cnt_o
`endif
);
  import dem_pkg::*;

  localparam int YW    = SWITCH_WIDTH + 1;
  localparam int CNT_W = cnt_width(WINDOW);
  localparam int ACC_W = acc_width(WINDOW, SWITCH_WIDTH);

  logic              accept;
  logic [YW-1:0]     x1_ext;
  logic [YW-1:0]     x2_ext;
  logic [YW-1:0]     sum;
  logic [ACC_W-1:0]  s_ext;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0] acc_wide;
  logic [ACC_W:0]    acc_abs;
  logic [CNT_W-1:0]  count;
  logic              window_end;
  logic              over_limit;
  dem_state_e        state;
  dem_state_e        state_next;

  assign accept = valid_i & ready_o;
  assign x1_ext = {x_out1_i[SWITCH_WIDTH-1], x_out1_i};
  assign x2_ext = {x_out2_i[SWITCH_WIDTH-1], x_out2_i};
  assign sum    = x1_ext + x2_ext;

  dem_skid_fifo #(
    .DATA_W(YW)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (reset_i),
    .s_tdata (sum),
    .s_tvalid(valid_i),
    .s_tready(ready_o),
    .m_tdata (y_o),
    .m_tvalid(valid_o),
    .m_tready(ready_i)
  );

  // The check sees the sum including the word that closes the window
  assign s_ext      = {{(ACC_W-SWITCH_WIDTH){s_in_i[SWITCH_WIDTH-1]}}, s_in_i};
  assign acc_sum    = acc + s_ext;
  assign acc_wide   = {acc_sum[ACC_W-1], acc_sum};
  assign acc_abs    = acc_wide[ACC_W] ? -acc_wide : acc_wide;
  assign over_limit = acc_abs > (ACC_W+1)'(BAL_LIMIT);
  assign window_end = accept && (count == CNT_W'(WINDOW-1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc   <= '0;
      count <= '0;
    end else if (clear_i) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      if (window_end) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= acc_sum;
        count <= count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = TRACK;
      TRACK:   if (window_end && over_limit) state_next = FAULT;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
    if (clear_i) begin
      state_next = IDLE;
    end
  end

  assign imbalance_o = (state == FAULT);
  assign state_o     = state;

`ifdef DEM_DEC_CHECK_EN
  logic [YW-1:0] diff;
  logic [YW-1:0] s_chk;
  logic          mismatch;

  assign diff     = x1_ext - x2_ext;
  assign s_chk    = {s_in_i[SWITCH_WIDTH-1], s_in_i};
  assign mismatch = (diff != s_chk);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_cnt_o <= '0;
    end else if (clear_i) begin
      err_cnt_o <= '0;
    end else if (accept && mismatch && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
      err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dem_decoder.md
DEM_DECODER -- requirements
Module: dem_decoder

Interface
REQ-001 Parameter SWITCH_WIDTH, 8, width of each signed switching-block element word.
REQ-002 Parameter WINDOW, 64, number of accepted samples per balance window; power of two, minimum 4.
REQ-003 Parameter BAL_LIMIT, 16, maximum allowed |sum of s| over one window.
REQ-004 clk_i  in  1  single clock; all state is updated on its rising edge.
REQ-005 reset_i  in  1  reset, asynchronous and active-high.
REQ-006 valid_i  in  1  input word qualifier.
REQ-007 ready_o  out  1  block can accept an input word this cycle.
REQ-008 x_out1_i  in  SWITCH_WIDTH  signed upper-branch value from the switching block.
REQ-009 x_out2_i  in  SWITCH_WIDTH  signed lower-branch value from the switching block.
REQ-010 s_in_i  in  SWITCH_WIDTH  signed switching sequence sent with the word.
REQ-011 clear_i  in  1  synchronous clear of the fault state and the counters.
REQ-012 y_o  out  SWITCH_WIDTH+1  signed reconstructed code.
REQ-013 valid_o  out  1  y_o qualifier.
REQ-014 ready_i  in  1  downstream accept.
REQ-015 imbalance_o  out  1  sticky flag: a window exceeded BAL_LIMIT.
REQ-016 state_o  out  2  current FSM state encoding.

Function
REQ-017 An input word shall be accepted on a cycle where valid_i and ready_o are both high; y_o shall equal x_out1_i + x_out2_i, computed at SWITCH_WIDTH+1 bits with sign extension and no saturation.
REQ-018 The output path shall be a 2-entry FIFO; ready_o = not full; valid_o = not empty; an entry pops when valid_o and ready_i are both high.
REQ-019 Latency from acceptance to valid_o shall be exactly 1 cycle when the FIFO is empty; data order shall be preserved.
REQ-020 A push and a pop in the same cycle while full shall not happen, because ready_o is low when full; a push and a pop in the same cycle while holding 1 entry shall leave the occupancy at 1 with the new word.
REQ-021 Each accepted word shall add sign-extended s_in_i to the balance accumulator acc, which is $clog2(WINDOW)+SWITCH_WIDTH bits wide and signed.
REQ-022 A window counter shall count accepted words 0..WINDOW-1 and wrap; on the word that makes count = WINDOW-1, |acc + s_in_i| shall be compared with BAL_LIMIT, and both acc and count shall restart at 0 on the next cycle.
REQ-023 FSM states: IDLE=0, TRACK=1, FAULT=2. IDLE goes to TRACK on the first accepted word. TRACK goes to FAULT when a window check exceeds BAL_LIMIT (a value equal to BAL_LIMIT passes). FAULT goes to IDLE on clear_i.
REQ-024 imbalance_o shall be high exactly while in FAULT; data continues to flow in FAULT and accumulation continues without re-checking.
REQ-025 clear_i shall zero acc, the window counter and the error counter and force IDLE, without touching the FIFO; if clear_i and an accepted word occur in the same cycle, clear_i wins for the counters and the word is still pushed.

Reset
REQ-026 When reset_i is asserted, at any time including mid-window: FIFO emptied, valid_o=0, y_o=0, ready_o=1 after release, acc=0, counter=0, state=IDLE, imbalance_o=0, err_cnt_o=0.

Configuration
REQ-027 With DEM_DEC_CHECK_EN defined: add output err_cnt_o (16 bits, saturating) that increments for each accepted word where x_out1_i - x_out2_i (SWITCH_WIDTH+1 bits) is not equal to sign-extended s_in_i.
REQ-028 Without DEM_DEC_CHECK_EN: no err_cnt_o port and no compare logic; all other behaviour is identical.

Structure
REQ-029 Shared package dem_pkg shall hold SWITCH_WIDTH, the dem_state_e enum {IDLE, TRACK, FAULT} and the width helper constants.
REQ-030 The 2-entry FIFO shall be a separate sub-module, dem_skid_fifo, parameterised by data width.

Verification
REQ-031 Reset, then accept x1=25, x2=25, s=0 with ready_i=1: y_o=50 and valid_o=1 one cycle later; state=TRACK.
REQ-032 Accept x1=-25, x2=-25 then x1=127, x2=127: y_o=-50, then 254 with no overflow.
REQ-033 ready_i=0 during 3 valid words: ready_o falls after 2 words, the third word is held, and raising ready_i drains 50, 0, -50 in order.
REQ-034 WINDOW=64 with s=+1 on every word: the window sum is 64 > 16, so state=FAULT and imbalance_o=1 on the cycle after the 64th word; clear_i returns the state to IDLE.
REQ-035 Alternating s=+1/-1 for 256 words: imbalance_o stays 0; assert reset_i at word 30 and check every output returns to its reset value.
REQ-036 With DEM_DEC_CHECK_EN defined, send x1=10, x2=4, s=5: err_cnt_o=1; send x1=10, x2=4, s=6: err_cnt_o stays 1.
